// File: rtl/adder_tree_accumulator_pkg.sv
// Shared constants and helpers for the adder tree and its downstream accumulator.
package adder_tree_pkg;

   localparam int TREE_SUM_W    = 8;
   localparam int ACC_W_DEFAULT = 16;
   localparam int TERMS_DEFAULT = 4;

   // Bits needed to hold values 0..n-1; use clog2(n+1) to size a counter that reaches n.
   function automatic int clog2(input int n);
      int w;
      w = 0;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/adder_tree_accumulator_sat_adder.sv
// Unsigned WIDTH-bit adder that clamps to all-ones on carry-out and reports the clamp.
module sat_adder #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum,
   output logic             ovf
);

   logic [WIDTH:0] full_sum;

   assign full_sum = {1'b0, a} + {1'b0, b};
   assign ovf      = full_sum[WIDTH];
   assign sum      = ovf ? {WIDTH{1'b1}} : full_sum[WIDTH-1:0];

endmodule

// File: rtl/adder_tree_accumulator.sv
// Accumulates tree sums into one saturated result per window, presented on a valid/ready register.
module adder_tree_accumulator
   import adder_tree_pkg::*;
#(
   parameter int IN_WIDTH  = TREE_SUM_W,
   parameter int ACC_WIDTH = ACC_W_DEFAULT,
   parameter int NUM_TERMS = TERMS_DEFAULT,
   parameter int CNT_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   input  logic [IN_WIDTH-1:0]  in_sum,
   input  logic                 in_last,
   output logic                 in_ready,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ACC_WIDTH-1:0] out_acc,
   output logic [CNT_WIDTH-1:0] out_count,
   output logic                 out_sat,
   output logic                 overrun
);

   logic [ACC_WIDTH-1:0] acc;
   logic [CNT_WIDTH-1:0] cnt;
   logic                 sat_run;

   logic [ACC_WIDTH-1:0] acc_base;
   logic [ACC_WIDTH-1:0] in_ext;
   logic [ACC_WIDTH-1:0] sum;
   logic                 ovf;
   logic [CNT_WIDTH-1:0] cnt_next;
   logic                 accept;
   logic                 final_beat;

   // The tree cannot stall, so readiness depends only on the output register.
   assign in_ready   = !(out_valid && !out_ready);
   assign accept     = in_valid && in_ready;
   assign acc_base   = (cnt == '0) ? '0 : acc;
   assign in_ext     = ACC_WIDTH'(in_sum);
   assign cnt_next   = cnt + 1'b1;
   assign final_beat = (cnt_next == CNT_WIDTH'(NUM_TERMS)) || in_last;

   sat_adder #(
      .WIDTH (ACC_WIDTH)
   ) u_sat_adder (
      .a   (acc_base),
      .b   (in_ext),
      .sum (sum),
      .ovf (ovf)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         acc       <= '0;
         cnt       <= '0;
         sat_run   <= 1'b0;
         out_valid <= 1'b0;
         out_acc   <= '0;
         out_count <= '0;
         out_sat   <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (out_valid && out_ready)
            out_valid <= 1'b0;
         if (in_valid && !in_ready)
            overrun <= 1'b1;
         // A final beat in the same cycle as a pop overrides the clear above.
         if (accept) begin
            if (final_beat) begin
               out_acc   <= sum;
               out_count <= cnt_next;
               out_sat   <= sat_run | ovf;
               out_valid <= 1'b1;
               acc       <= '0;
               cnt       <= '0;
               sat_run   <= 1'b0;
            end else begin
               acc     <= sum;
               cnt     <= cnt_next;
               sat_run <= sat_run | ovf;
            end
         end
      end
   end

endmodule

// File: tb/tb_adder_tree_accumulator.sv
// Directed bench: default config, a 9-bit/3-term saturating config and a single-term config.
module tb_adder_tree_accumulator;

   logic clk;
   logic reset;

   logic        a_in_valid, a_in_last, a_in_ready, a_out_valid, a_out_ready, a_out_sat, a_overrun;
   logic [7:0]  a_in_sum;
   logic [15:0] a_out_acc;
   logic [3:0]  a_out_count;

   logic        b_in_valid, b_in_last, b_in_ready, b_out_valid, b_out_ready, b_out_sat, b_overrun;
   logic [7:0]  b_in_sum;
   logic [8:0]  b_out_acc;
   logic [3:0]  b_out_count;

   logic        c_in_valid, c_in_last, c_in_ready, c_out_valid, c_out_ready, c_out_sat, c_overrun;
   logic [7:0]  c_in_sum;
   logic [15:0] c_out_acc;
   logic [3:0]  c_out_count;

   int n_cmp;
   int n_bad;

   adder_tree_accumulator u_dut_a (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (a_in_valid),
      .in_sum    (a_in_sum),
      .in_last   (a_in_last),
      .in_ready  (a_in_ready),
      .out_valid (a_out_valid),
      .out_ready (a_out_ready),
      .out_acc   (a_out_acc),
      .out_count (a_out_count),
      .out_sat   (a_out_sat),
      .overrun   (a_overrun)
   );

   adder_tree_accumulator #(
      .IN_WIDTH  (8),
      .ACC_WIDTH (9),
      .NUM_TERMS (3),
      .CNT_WIDTH (4)
   ) u_dut_b (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (b_in_valid),
      .in_sum    (b_in_sum),
      .in_last   (b_in_last),
      .in_ready  (b_in_ready),
      .out_valid (b_out_valid),
      .out_ready (b_out_ready),
      .out_acc   (b_out_acc),
      .out_count (b_out_count),
      .out_sat   (b_out_sat),
      .overrun   (b_overrun)
   );

   adder_tree_accumulator #(
      .NUM_TERMS (1)
   ) u_dut_c (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (c_in_valid),
      .in_sum    (c_in_sum),
      .in_last   (c_in_last),
      .in_ready  (c_in_ready),
      .out_valid (c_out_valid),
      .out_ready (c_out_ready),
      .out_acc   (c_out_acc),
      .out_count (c_out_count),
      .out_sat   (c_out_sat),
      .overrun   (c_overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Each beat task applies inputs, then returns #1 after the capturing edge.
   task automatic beat_a(input logic v, input logic [7:0] s, input logic l);
      a_in_valid = v;
      a_in_sum   = s;
      a_in_last  = l;
      @(posedge clk);
      #1;
   endtask

   task automatic beat_b(input logic v, input logic [7:0] s, input logic l);
      b_in_valid = v;
      b_in_sum   = s;
      b_in_last  = l;
      @(posedge clk);
      #1;
   endtask

   task automatic beat_c(input logic v, input logic [7:0] s, input logic l);
      c_in_valid = v;
      c_in_sum   = s;
      c_in_last  = l;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_a(input string tag, input logic v, input logic [15:0] acc,
                        input logic [3:0] cnt, input logic sat);
      chk({tag, "_valid"}, a_out_valid, v);
      chk({tag, "_acc"},   a_out_acc,   acc);
      chk({tag, "_count"}, a_out_count, cnt);
      chk({tag, "_sat"},   a_out_sat,   sat);
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      reset = 1'b1;
      a_in_valid = 0; a_in_sum = 0; a_in_last = 0; a_out_ready = 1;
      b_in_valid = 0; b_in_sum = 0; b_in_last = 0; b_out_ready = 1;
      c_in_valid = 0; c_in_sum = 0; c_in_last = 0; c_out_ready = 1;
      repeat (2) @(posedge clk);
      #1;
      chk_a("rst", 0, 0, 0, 0);
      chk("rst_overrun", a_overrun, 0);
      chk("rst_b_valid", b_out_valid, 0);
      chk("rst_c_valid", c_out_valid, 0);
      chk("rst_in_ready", a_in_ready, 1);
      reset = 1'b0;

      // Full window of four, then an early-closed window starting right away.
      beat_a(1, 10, 0);
      beat_a(1, 20, 0);
      beat_a(1, 30, 0);
      chk("mid_window_valid", a_out_valid, 0);
      beat_a(1, 40, 0);
      chk_a("win4", 1, 100, 4, 0);
      beat_a(1, 7, 0);
      chk("pop_valid", a_out_valid, 0);
      beat_a(1, 9, 1);
      chk_a("last2", 1, 16, 2, 0);

      // Bubble inside a window holds state.
      beat_a(1, 5, 0);
      beat_a(0, 0, 0);
      chk("bubble_valid", a_out_valid, 0);
      beat_a(1, 6, 1);
      chk_a("bubble", 1, 11, 2, 0);
      beat_a(0, 0, 0);

      // Blocked output: drop a beat, flag overrun, then pop.
      a_out_ready = 0;
      beat_a(1, 3, 1);
      chk_a("first_last", 1, 3, 1, 0);
      #1;
      chk("blocked_in_ready", a_in_ready, 0);
      beat_a(1, 50, 0);
      chk("overrun_set", a_overrun, 1);
      chk_a("held", 1, 3, 1, 0);
      a_out_ready = 1;
      #1;
      chk("unblocked_in_ready", a_in_ready, 1);
      beat_a(0, 0, 0);
      chk("popped_valid", a_out_valid, 0);
      chk("overrun_sticky", a_overrun, 1);
      beat_a(1, 1, 0);
      beat_a(1, 1, 1);
      chk_a("after_drop", 1, 2, 2, 0);

      // Pop and a new final beat in the same cycle.
      beat_a(1, 12, 1);
      chk_a("pop_and_final", 1, 12, 1, 0);

      // Reset mid-window, with a beat presented during reset.
      beat_a(1, 50, 0);
      beat_a(1, 60, 0);
      reset = 1'b1;
      beat_a(1, 70, 0);
      chk_a("rst_mid", 0, 0, 0, 0);
      chk("rst_mid_overrun", a_overrun, 0);
      reset = 1'b0;
      beat_a(1, 1, 0);
      beat_a(1, 2, 0);
      beat_a(1, 3, 0);
      beat_a(1, 4, 0);
      chk_a("post_rst", 1, 10, 4, 0);
      beat_a(0, 0, 0);

      // 9-bit accumulator, three terms: saturation then a clean window.
      beat_b(1, 255, 0);
      beat_b(1, 255, 0);
      beat_b(1, 255, 0);
      chk("sat_valid", b_out_valid, 1);
      chk("sat_acc",   b_out_acc,   511);
      chk("sat_count", b_out_count, 3);
      chk("sat_flag",  b_out_sat,   1);
      beat_b(1, 1, 0);
      beat_b(1, 1, 0);
      beat_b(1, 1, 0);
      chk("clean_acc", b_out_acc, 3);
      chk("clean_sat", b_out_sat, 0);
      chk("b_overrun", b_overrun, 0);
      beat_b(0, 0, 0);

      // Single-term windows: every beat is final.
      beat_c(1, 5, 0);
      chk("t1_valid", c_out_valid, 1);
      chk("t1_acc",   c_out_acc,   5);
      chk("t1_count", c_out_count, 1);
      beat_c(1, 6, 0);
      chk("t1b_acc",   c_out_acc,   6);
      chk("t1b_count", c_out_count, 1);
      beat_c(0, 0, 0);
      chk("t1_drain", c_out_valid, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/adder_tree_accumulator.md
Name: adder_tree_accumulator

Overview:
- Downstream consumer of the 3-stage 4-bit adder tree. Accumulates successive 8-bit tree sums into one wide result per window of NUM_TERMS beats, or fewer if in_last closes the window early.
- Presents each completed result on a valid/ready output register and saturates on overflow.
- The tree cannot stall. A beat that arrives while the output is blocked is dropped and flagged with a sticky overrun bit.

Parameters:
- IN_WIDTH, 8, width of the incoming tree sum.
- ACC_WIDTH, 16, accumulator and result width; must be >= IN_WIDTH.
- NUM_TERMS, 4, beats per window; range 1..2^CNT_WIDTH-1.
- CNT_WIDTH, 4, width of the beat counter and of out_count.

Ports:
- clk  in  1  clock, all state updates on the rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  in_sum carries a valid tree result this cycle; upstream aligns it to the tree's 3-cycle latency
- in_sum  in  IN_WIDTH  tree sum, unsigned
- in_last  in  1  closes the current window on this beat, qualified by in_valid
- in_ready  out  1  block can accept a beat this cycle
- out_valid  out  1  out_acc / out_count / out_sat hold a completed result
- out_ready  in  1  consumer takes the result when out_valid && out_ready
- out_acc  out  ACC_WIDTH  accumulated sum, unsigned, saturated
- out_count  out  CNT_WIDTH  number of beats in the window
- out_sat  out  1  saturation occurred in this window
- overrun  out  1  sticky; a beat arrived while in_ready=0

Behaviour:
- Reset (synchronous, active-high; clock clk):
  - acc, cnt, sat_run, out_valid, out_acc, out_count, out_sat and overrun all clear to 0.
  - Reset mid-window discards partial state.
  - Reset dominates every other event in the same cycle.
- in_ready:
  - Combinational: in_ready = !(out_valid && !out_ready).
  - No dependency on in_valid.
- Accept: a beat is accepted when in_valid && in_ready.
- Saturating add: sum = (cnt==0 ? 0 : acc) + zero-extend(in_sum).
  - If sum > 2^ACC_WIDTH-1, the result clamps to all-ones and the saturation flag is set for the window.
  - Once clamped, the accumulator stays clamped for the rest of the window.
- Non-final accepted beat (cnt+1 < NUM_TERMS and !in_last):
  - acc <= sum; cnt <= cnt+1; sat_run <= sat_run | ovf.
- Final accepted beat (cnt+1 == NUM_TERMS or in_last):
  - out_acc <= sum; out_count <= cnt+1; out_sat <= sat_run | ovf; out_valid <= 1.
  - cnt <= 0; acc <= 0; sat_run <= 0.
- Latency: result is visible the cycle after the final beat is accepted.
- Back-to-back windows run at full rate while out_ready=1.
- Output handshake:
  - out_valid && out_ready with no new final beat: out_valid <= 0.
  - Simultaneous pop and final beat: out_valid stays 1 and the new result replaces the old one in the same cycle.
  - While out_valid && !out_ready, out_acc, out_count and out_sat hold stable.
- Overrun: in_valid && !in_ready means the beat is dropped, acc and cnt are unchanged, and overrun <= 1. overrun clears only on reset.
- Boundaries:
  - NUM_TERMS=1: every beat is final.
  - in_last on the first beat gives out_count=1.
  - in_valid=0 cycles inside a window are bubbles; the window state holds.

Decomposition:
- Package adder_tree_pkg holds:
  - default constants TREE_SUM_W=8, ACC_W_DEFAULT=16, TERMS_DEFAULT=4;
  - function clog2 for sizing CNT_WIDTH.
- One natural sub-module, sat_adder (parameterised width, output = sum plus overflow flag). It is instantiated once in the accumulator and reusable by later tree stages.

Test Plan:
- Defaults, out_ready=1, sums 10,20,30,40 on consecutive cycles -> one cycle later out_valid=1, out_acc=100, out_count=4, out_sat=0; next window starts immediately.
- Sums 7,9 with in_last on the second beat -> out_acc=16, out_count=2; the following window starts from 0.
- ACC_WIDTH=9, NUM_TERMS=3, sums 255,255,255 -> out_acc=511, out_sat=1; the next window 1,1,1 gives out_acc=3, out_sat=0.
- out_ready=0 while a result is pending, then one in_valid beat -> in_ready=0, beat dropped, overrun=1 and stays 1. out_acc is unchanged; raising out_ready pops the result.
- Pop and final beat in the same cycle -> out_valid stays 1, out_acc updates to the new window value, no beat is lost.
- Reset asserted after 2 of 4 beats (sums 50,60), then 1,2,3,4 -> out_acc=10, out_count=4; all outputs read 0 during reset.
